apb_rr_arbiter: RTL and testbench

Round-robin arbiter sharing a single APB master port among NUM_REQ independent requesters. Each requester presents a read or write command; the arbiter grants one at a time, runs the full APB SETUP/ACCESS sequence on the shared bus and returns a one-cycle completion pulse, plus read data, to the granted requester. It sits between the command sources (e.g. the read / increment-write sequencers) and the APB slave fabric, replacing the per-source APB master.

---
 rtl/apb_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// Grants one command at a time, runs SETUP/ACCESS, and returns a one-cycle completion pulse.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic                      pready_i,
  input  logic [DATA_W-1:0]         prdata_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]    grant_reg, grant_next;
  logic [IDX_W-1:0]    pick;
  logic                pick_found;
  logic [ADDR_W-1:0]   paddr_reg, paddr_next;
  logic [DATA_W-1:0]   pwdata_reg, pwdata_next;
  logic                pwrite_reg, pwrite_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic [NUM_REQ-1:0]  rsp_valid_reg, rsp_valid_next;
  logic [NUM_REQ-1:0]  ready;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic [SUM_W-1:0]    cand_sum  [NUM_REQ];
  logic [IDX_W-1:0]    cand_idx  [NUM_REQ];

  // Unpack the flattened buses and build the rotated search order starting at rr_ptr.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata_i[gi*DATA_W +: DATA_W];
      assign cand_sum[gi]  = {1'b0, rr_ptr_reg} + SUM_W'(gi);
      assign cand_idx[gi]  = (cand_sum[gi] >= SUM_W'(NUM_REQ))
                             ? IDX_W'(cand_sum[gi] - SUM_W'(NUM_REQ))
                             : cand_sum[gi][IDX_W-1:0];
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    pick       = rr_ptr_reg;
    pick_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[cand_idx[i]]) begin
        pick       = cand_idx[i];
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_next     = grant_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    pwrite_next    = pwrite_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_valid_next = '0;
    ready          = '0;
    case (state_reg)
      IDLE: begin
        if (pick_found && !reset) begin
          ready[pick] = 1'b1;
          grant_next  = pick;
          paddr_next  = addr_arr[pick];
          pwrite_next = req_write_i[pick];
          if (req_write_i[pick]) begin
            pwdata_next = wdata_arr[pick];
          end
          state_next  = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          rsp_valid_next[grant_reg] = 1'b1;
          rsp_rdata_next = pwrite_reg ? '0 : prdata_i;
          // Pointer moves only on completion so the next search starts past the winner.
          rr_ptr_next    = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pwrite_reg    <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_valid_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_reg     <= grant_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      pwrite_reg    <= pwrite_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  assign req_ready_o = ready;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign psel_o      = (state_reg != IDLE);
  assign penable_o   = (state_reg == ACCESS);
  assign pwrite_o    = pwrite_reg;
  assign paddr_o     = paddr_reg;
  assign pwdata_o    = pwdata_reg;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_apb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid_i, req_write_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_wdata_i;
  logic [N-1:0]      req_ready_o, rsp_valid_o;
  logic [DW-1:0]     rsp_rdata_o;
  logic              psel_o, penable_o, pwrite_o;
  logic [AW-1:0]     paddr_o;
  logic [DW-1:0]     pwdata_o;
  logic              pready_i;
  logic [DW-1:0]     prdata_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          rr_ptr_m;
  logic [DW-1:0] last_rdata_m, last_pwdata_m;
  logic [AW-1:0] last_paddr_m;
  logic          last_pwrite_m;
  logic          m_write [N];
  logic [AW-1:0] m_addr  [N];
  logic [DW-1:0] m_wdata [N];

  apb_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .pready_i(pready_i), .prdata_i(prdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_i[k] = 1'b1;
    req_write_i[k] = w;
    req_addr_i[k*AW +: AW]  = a;
    req_wdata_i[k*DW +: DW] = d;
    m_write[k] = w;
    m_addr[k]  = a;
    m_wdata[k] = d;
  endtask

  function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (pend[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    rr_ptr_m      = 0;
    last_rdata_m  = '0;
    last_pwdata_m = '0;
    last_paddr_m  = '0;
    last_pwrite_m = 1'b0;
  endfunction

  // Called at a negedge with the DUT idle and at least one request pending.
  // Returns at the negedge of the completion cycle.
  task automatic run_xfer(input int wait_c, input logic [DW-1:0] rdata, output int g);
    logic [AW-1:0] a;
    logic [DW-1:0] exp_r;
    logic          w;
    int            psel_cnt;
    psel_cnt = 0;
    #1;
    g = model_pick(req_valid_i, rr_ptr_m);
    if (g < 0) begin
      $display("FAIL run_xfer: no pending request in bench");
      $fatal(1);
    end
    chk("accept_ready", req_ready_o, 64'(1) << g);
    a = m_addr[g];
    w = m_write[g];
    if (w) last_pwdata_m = m_wdata[g];
    last_paddr_m  = a;
    last_pwrite_m = w;
    @(posedge clk);
    @(negedge clk);
    req_valid_i[g] = 1'b0;
    psel_cnt += psel_o;
    chk("setup_ctl", {psel_o, penable_o}, 2'b10);
    chk("setup_paddr", paddr_o, a);
    chk("setup_pwrite", pwrite_o, w);
    chk("setup_pwdata", pwdata_o, last_pwdata_m);
    chk("setup_ready", req_ready_o, 0);
    pready_i = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int i = 0; i <= wait_c; i++) begin
      @(negedge clk);
      psel_cnt += psel_o;
      chk("access_ctl", {psel_o, penable_o}, 2'b11);
      chk("access_paddr", paddr_o, a);
      chk("access_pwrite", pwrite_o, w);
      chk("access_pwdata", pwdata_o, last_pwdata_m);
      chk("access_no_rsp", rsp_valid_o, 0);
      chk("rdata_hold", rsp_rdata_o, last_rdata_m);
      pready_i = (i == wait_c);
      prdata_i = (i == wait_c) ? rdata : $urandom;
      @(posedge clk);
    end
    @(negedge clk);
    pready_i = 1'b0;
    psel_cnt += psel_o;
    exp_r = w ? '0 : rdata;
    chk("rsp_valid", rsp_valid_o, 64'(1) << g);
    chk("rsp_rdata", rsp_rdata_o, exp_r);
    chk("rsp_ctl", {psel_o, penable_o}, 2'b00);
    chk("psel_cycles", psel_cnt, wait_c + 2);
    chk("idle_paddr_hold", paddr_o, a);
    last_rdata_m = exp_r;
    rr_ptr_m = (g + 1) % N;
    $display("xfer req=%0d %s addr=%h wdata=%h rdata=%h wait=%0d", g, w ? "WR" : "RD",
             a, w ? m_wdata[g] : '0, exp_r, wait_c);
  endtask

  initial begin
    int g;
    int done, issued;
    int grants02 [4];
    grants02 = '{0, 2, 0, 2};
    reset = 1'b1;
    req_valid_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
    pready_i = 1'b0; prdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset values, with every requester already valid.
    for (int k = 0; k < N; k++) issue(k, 1'b0, 32'h1000 + 32'(k * 4), '0);
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_ctl", {psel_o, penable_o, pwrite_o}, 3'b000);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_pwdata", pwdata_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    @(negedge clk);
    reset = 1'b0;

    // Contention: all four from reset, zero-wait.
    for (int k = 0; k < N; k++) begin
      run_xfer(0, 32'hA0 + 32'(k), g);
      chk("contention_order", g, k);
    end
    // Only 0 and 2 keep requesting.
    issue(0, 1'b1, 32'h2000, 32'h11);
    issue(2, 1'b1, 32'h2008, 32'h22);
    for (int t = 0; t < 4; t++) begin
      run_xfer(0, '0, g);
      chk("alt_order", g, grants02[t]);
      issue(g, 1'b0, 32'h3000 + 32'(t), '0);
    end
    // Drain the leftover requests from the alternation phase.
    while (req_valid_i != '0) run_xfer(0, 32'h5A, g);

    // Single read with two wait cycles.
    issue(1, 1'b0, 32'hDEAD_CAFE, '0);
    run_xfer(2, 32'h0000_0005, g);
    chk("single_read_grant", g, 1);

    // Single write, zero-wait.
    issue(0, 1'b1, 32'hDEAD_CAFE, 32'h6);
    run_xfer(0, 32'hFFFF_FFFF, g);
    chk("single_write_grant", g, 0);

    // Read-increment-write; the write is accepted in the completion cycle.
    issue(2, 1'b0, 32'hDEAD_CAFE, '0);
    run_xfer(1, 32'hF, g);
    issue(2, 1'b1, 32'hDEAD_CAFE, last_rdata_m + 1);
    run_xfer(0, '0, g);
    chk("riw_grant", g, 2);
    chk("riw_pwdata", pwdata_o, 32'h10);
    chk("riw_pwrite", pwrite_o, 1);

    // Randomized mixed traffic.
    done = 0;
    issued = 0;
    while (done < 100) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid_i[k] && issued < 100 && $urandom_range(0, 2) != 0) begin
          issue(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
          issued++;
        end
      end
      if (req_valid_i == '0) begin
        issue($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom, $urandom);
        issued++;
      end
      run_xfer($urandom_range(1, 10), $urandom, g);
      done++;
    end

    // Reset during ACCESS with pready low.
    issue(1, 1'b0, 32'h4444, '0);
    run_xfer(0, 32'h7, g);
    issue(3, 1'b1, 32'h5555, 32'h99);
    #1;
    chk("rstacc_ready", req_ready_o, 4'b1000);
    @(posedge clk);
    @(negedge clk);
    req_valid_i[3] = 1'b0;
    pready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstacc_in_access", {psel_o, penable_o}, 2'b11);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstacc_ctl", {psel_o, penable_o}, 2'b00);
    chk("rstacc_no_rsp", rsp_valid_o, 0);
    for (int k = 0; k < N; k++) issue(k, 1'b0, 32'h6000 + 32'(k), '0);
    #1;
    chk("rstacc_ready_in_reset", req_ready_o, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rstacc_no_rsp2", rsp_valid_o, 0);
    reset = 1'b0;
    model_reset();
    chk("rstacc_rdata", rsp_rdata_o, last_rdata_m);
    chk("rstacc_paddr", paddr_o, last_paddr_m);
    run_xfer(0, 32'h1, g);
    chk("rstacc_first_grant", g, 0);
    while (req_valid_i != '0) run_xfer(0, 32'h2, g);

    // Idle: nothing granted, APB fields hold.
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("idle_ready", req_ready_o, 0);
      chk("idle_ctl", {psel_o, penable_o}, 2'b00);
      chk("idle_paddr", paddr_o, last_paddr_m);
      chk("idle_pwrite", pwrite_o, last_pwrite_m);
      chk("idle_rdata", rsp_rdata_o, last_rdata_m);
      chk("idle_rsp", rsp_valid_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
